wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32I pipeline; the producer side of the register-file write port (rd_addr / regWrite / rd_data).
- Accepts retiring instructions from MEM through a valid/ready handshake.
- Waits for data-memory load responses, aligns and sign/zero-extends load data, and selects the writeback source.
- Drives one registered register-file write per cycle, a load-pending hazard indication, and a retire counter.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage can accept; combinational, = (state != LOAD_WAIT)
- in_reg_write  in  1  instruction writes rd
- in_rd_addr  in  5  destination register
- in_wb_sel  in  2  00 ALU result, 01 load data, 10 PC+4, 11 ALU result
- in_alu_result  in  XLEN  ALU result / load byte address
- in_pc  in  XLEN  instruction PC
- in_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- mem_rsp_valid  in  1  data memory returns load word
- mem_rsp_data  in  XLEN  raw aligned 32-bit word
- reg_write  out  1  register-file write enable (registered)
- rd_addr  out  5  register-file write address (registered)
- rd_data  out  XLEN  register-file write data (registered)
- load_pending  out  1  a load is waiting for memory
- load_rd  out  5  destination of pending load
- misalign_err  out  1  one-cycle pulse on misaligned load
- retire_count  out  CNT_W  instructions completed since reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE; reg_write=0, rd_addr=0, rd_data=0, load_pending=0, load_rd=0, misalign_err=0, retire_count=0. Consequently in_ready=1.
- Accept = in_valid & in_ready, sampled at the rising edge.
- States: IDLE, LOAD_WAIT.
- IDLE, accept with in_wb_sel!=01:
  - Next cycle: reg_write = in_reg_write & (in_rd_addr!=0); rd_addr=in_rd_addr.
  - rd_data = in_alu_result, or in_pc+4 (mod 2^32) when wb_sel=10.
  - retire_count += 1. Stay IDLE. Latency 1; back-to-back accepts give one write per cycle.
- IDLE, accept with in_wb_sel=01:
  - Latch rd, reg_write, funct3 and alu_result[1:0]; load_pending=1, load_rd=in_rd_addr.
  - Go to LOAD_WAIT. reg_write=0 the next cycle.
- LOAD_WAIT:
  - in_ready=0; mem_rsp_valid is sampled only in this state.
  - On mem_rsp_valid: the next cycle drives reg_write/rd_addr/rd_data with the aligned value; load_pending=0; retire_count += 1; go to IDLE.
  - Without mem_rsp_valid: hold, reg_write=0.
- mem_rsp_valid in IDLE is ignored.
- Load alignment, offset o = addr[1:0]:
  - LB/LBU: byte mem_rsp_data[8o+7:8o], sign/zero-extended.
  - LH/LHU: halfword at o∈{0,2}, sign/zero-extended.
  - LW: whole word, o=0.
  - funct3 011/110/111 are treated as LW.
- Misaligned load (LH/LHU with o∈{1,3}, or LW with o!=0):
  - Response is still awaited.
  - Completion cycle: reg_write=0, misalign_err=1 for one cycle; retire_count still increments.
- rd_addr=0 never asserts reg_write. rd_addr and rd_data still update.
- reg_write is a one-cycle pulse per completion: it is 0 in any cycle without a completion.
- retire_count wraps from all-ones to 0.
- Reset asserted mid-load: pending load dropped; a later mem_rsp_valid arriving in IDLE is ignored.

Test Plan:
- ALU op: rd=5, wb_sel=00, alu_result=0x1234_5678 → next cycle reg_write=1, rd_addr=5, rd_data=0x12345678, retire_count=1.
- Back-to-back: JAL rd=1 pc=0x100 (wb_sel=10), then ALU rd=0 → cycle1 write x1=0x104; cycle2 reg_write=0; retire_count=2; in_ready stays 1.
- Sign-extending load: LB rd=7 addr[1:0]=3, response after 3 cycles with data=0x80FF_0000 → in_ready=0 and load_pending=1, load_rd=7 during wait; then write x7=0xFFFFFF80; the LBU variant gives 0x00000080.
- LHU addr[1:0]=2, data 0xBEEF_0000 → 0x0000BEEF. Misaligned LW addr[1:0]=1 → misalign_err pulse, reg_write=0, retire_count increments.
- Stray response: mem_rsp_valid in IDLE → no write, counter unchanged.
- Async reset during LOAD_WAIT, then response → outputs zero immediately, in_ready=1, no write.
- Counter wrap: CNT_W=4, 16 ALU ops → retire_count=0.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : RV32I writeback stage. Accepts retiring instructions from MEM,
//                waits for data-memory load responses, aligns and extends the
//                load data, and drives one registered register-file write per
//                cycle together with a load-pending hazard flag and a retire
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd_addr,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [2:0]       in_funct3,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rsp_data,
    output logic             reg_write,
    output logic [4:0]       rd_addr,
    output logic [XLEN-1:0]  rd_data,
    output logic             load_pending,
    output logic [4:0]       load_rd,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [1:0] c_WB_LOAD = 2'b01;
    localparam logic [1:0] c_WB_PC4  = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_ld_we;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_off;

    logic              w_accept;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;
    logic              w_misalign;

    assign in_ready = (r_state == S_IDLE);
    assign w_accept = in_valid & in_ready;

    // Extract, extend and alignment-check the pending load from the raw word
    always_comb begin
        w_load_data = mem_rsp_data;
        w_misalign  = 1'b0;
        case (r_ld_off)
            2'd0:    w_byte = mem_rsp_data[7:0];
            2'd1:    w_byte = mem_rsp_data[15:8];
            2'd2:    w_byte = mem_rsp_data[23:16];
            default: w_byte = mem_rsp_data[31:24];
        endcase
        w_half = r_ld_off[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (r_ld_funct3)
            3'b000: w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001: begin
                w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
                w_misalign  = r_ld_off[0];
            end
            3'b101: begin
                w_load_data = {{(XLEN-16){1'b0}}, w_half};
                w_misalign  = r_ld_off[0];
            end
            // LW and the unused encodings 011/110/111 are all full-word loads
            default: begin
                w_load_data = mem_rsp_data;
                w_misalign  = |r_ld_off;
            end
        endcase
    end

    // Accept/load FSM with registered register-file write port and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ld_we      <= 1'b0;
            r_ld_funct3  <= 3'b000;
            r_ld_off     <= 2'b00;
            reg_write    <= 1'b0;
            rd_addr      <= 5'd0;
            rd_data      <= '0;
            load_pending <= 1'b0;
            load_rd      <= 5'd0;
            misalign_err <= 1'b0;
            retire_count <= '0;
        end else begin
            // Write enable and error flag are single-cycle pulses
            reg_write    <= 1'b0;
            misalign_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_wb_sel == c_WB_LOAD) begin
                            r_ld_we      <= in_reg_write;
                            r_ld_funct3  <= in_funct3;
                            r_ld_off     <= in_alu_result[1:0];
                            load_pending <= 1'b1;
                            load_rd      <= in_rd_addr;
                            r_state      <= S_LOAD_WAIT;
                        end else begin
                            reg_write    <= in_reg_write & (in_rd_addr != 5'd0);
                            rd_addr      <= in_rd_addr;
                            rd_data      <= (in_wb_sel == c_WB_PC4) ? (in_pc + XLEN'(4))
                                                                     : in_alu_result;
                            retire_count <= retire_count + CNT_W'(1);
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    if (mem_rsp_valid) begin
                        // A misaligned load still retires, but never writes rd
                        reg_write    <= r_ld_we & (load_rd != 5'd0) & ~w_misalign;
                        misalign_err <= w_misalign;
                        rd_addr      <= load_rd;
                        rd_data      <= w_load_data;
                        load_pending <= 1'b0;
                        retire_count <= retire_count + CNT_W'(1);
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage: directed vector table,
//                multi-cycle corner sequences and randomized traffic against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_reg_write;
    logic [4:0]       in_rd_addr;
    logic [1:0]       in_wb_sel;
    logic [XLEN-1:0]  in_alu_result, in_pc;
    logic [2:0]       in_funct3;
    logic             mem_rsp_valid;
    logic [XLEN-1:0]  mem_rsp_data;
    logic             reg_write;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_data;
    logic             load_pending;
    logic [4:0]       load_rd;
    logic             misalign_err;
    logic [CNT_W-1:0] retire_count;

    int checks   = 0;
    int failures = 0;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr),
        .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
        .in_pc(in_pc), .in_funct3(in_funct3),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .load_pending(load_pending), .load_rd(load_rd),
        .misalign_err(misalign_err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    bit               m_pend;
    bit               m_we;
    logic [4:0]       m_rd;
    logic [2:0]       m_f3;
    logic [1:0]       m_off;
    logic [CNT_W-1:0] m_cnt;
    bit               e_we, e_mis, e_known;
    logic [4:0]       e_rd;
    logic [31:0]      e_data;

    task automatic model_reset();
        m_pend = 0; m_we = 0; m_rd = 0; m_f3 = 0; m_off = 0; m_cnt = 0;
        e_we = 0; e_mis = 0; e_known = 1; e_rd = 0; e_data = 0;
    endtask

    // Returns {misaligned, value} using plain shift/mask arithmetic
    function automatic logic [32:0] load_ref(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] v;
        int sh;
        sh = int'(off) * 8;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (w >> sh) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            return {1'b0, v};
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            if (off == 2'd1 || off == 2'd3) return {1'b1, 32'h0};
            v = (w >> sh) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            return {1'b0, v};
        end else begin
            if (off != 2'd0) return {1'b1, 32'h0};
            return {1'b0, w};
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict, advance, compare against the model
    task automatic step(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [2:0] f3, input logic rv, input logic [31:0] rdata);
        logic [32:0] r;
        in_valid = v; in_reg_write = rw; in_rd_addr = rd; in_wb_sel = sel;
        in_alu_result = alu; in_pc = pc; in_funct3 = f3;
        mem_rsp_valid = rv; mem_rsp_data = rdata;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_pend});
        e_we = 0; e_mis = 0;
        if (!m_pend) begin
            if (v) begin
                if (sel == 2'b01) begin
                    m_pend = 1; m_we = rw; m_rd = rd; m_f3 = f3; m_off = alu[1:0];
                end else begin
                    e_we = rw && (rd != 0); e_rd = rd; e_known = 1;
                    e_data = (sel == 2'b10) ? pc + 32'd4 : alu;
                    m_cnt = m_cnt + 1'b1;
                end
            end
        end else if (rv) begin
            r = load_ref(m_f3, m_off, rdata);
            m_pend = 0; m_cnt = m_cnt + 1'b1; e_rd = m_rd;
            if (r[32]) begin
                e_mis = 1; e_known = 0;
            end else begin
                e_we = m_we && (m_rd != 0); e_data = r[31:0]; e_known = 1;
            end
        end
        @(posedge clk); #1;
        chk("reg_write", {31'd0, reg_write}, {31'd0, e_we});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e_mis});
        chk("load_pending", {31'd0, load_pending}, {31'd0, m_pend});
        chk("retire_count", {28'd0, retire_count}, {28'd0, m_cnt});
        chk("rd_addr", {27'd0, rd_addr}, {27'd0, e_rd});
        if (e_known) chk("rd_data", rd_data, e_data);
        if (m_pend) chk("load_rd", {27'd0, load_rd}, {27'd0, m_rd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [2:0]  f3;
        int          wait_cyc;
        logic [31:0] rdata;
        logic        exp_we;
        logic        exp_mis;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{"alu_rd5",   1, 5, 2'b00, 32'h1234_5678, 32'h0,         0, 0, 32'h0,         1, 0, 32'h1234_5678};
        vt[1]  = '{"jal_rd1",   1, 1, 2'b10, 32'hDEAD_0000, 32'h100,       0, 0, 32'h0,         1, 0, 32'h0000_0104};
        vt[2]  = '{"alu_rd0",   1, 0, 2'b00, 32'h0000_0042, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0000_0042};
        vt[3]  = '{"lb_off3",   1, 7, 2'b01, 32'h0000_1003, 32'h0,         0, 3, 32'h80FF_0000, 1, 0, 32'hFFFF_FF80};
        vt[4]  = '{"lbu_off3",  1, 7, 2'b01, 32'h0000_1003, 32'h0,         4, 1, 32'h80FF_0000, 1, 0, 32'h0000_0080};
        vt[5]  = '{"lhu_off2",  1, 9, 2'b01, 32'h0000_2002, 32'h0,         5, 1, 32'hBEEF_0000, 1, 0, 32'h0000_BEEF};
        vt[6]  = '{"lh_off2",   1, 9, 2'b01, 32'h0000_2002, 32'h0,         1, 2, 32'hBEEF_0000, 1, 0, 32'hFFFF_BEEF};
        vt[7]  = '{"lw_off0",   1, 3, 2'b01, 32'h0000_3000, 32'h0,         2, 0, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D};
        vt[8]  = '{"lw_mis1",   1, 3, 2'b01, 32'h0000_3001, 32'h0,         2, 1, 32'hCAFE_F00D, 0, 1, 32'h0};
        vt[9]  = '{"lh_mis1",   1, 4, 2'b01, 32'h0000_3001, 32'h0,         1, 0, 32'h1111_2222, 0, 1, 32'h0};
        vt[10] = '{"sel11_alu", 1, 6, 2'b11, 32'h0BAD_BEEF, 32'h4,         0, 0, 32'h0,         1, 0, 32'h0BAD_BEEF};
        vt[11] = '{"jal_wrap",  1, 2, 2'b10, 32'h0,         32'hFFFF_FFFC, 0, 0, 32'h0,         1, 0, 32'h0000_0000};
        vt[12] = '{"lb_off1",   1, 8, 2'b01, 32'h0000_0001, 32'h0,         0, 0, 32'h0000_7F00, 1, 0, 32'h0000_007F};
        vt[13] = '{"no_rw",     0, 8, 2'b00, 32'h5555_5555, 32'h0,         0, 0, 32'h0,         0, 0, 32'h5555_5555};
    end

    task automatic run_vec(input vec_t t);
        step(1, t.rw, t.rd, t.sel, t.alu, t.pc, t.f3, 0, 0);
        if (t.sel == 2'b01) begin
            idle(t.wait_cyc);
            step(0, 0, 0, 0, 0, 0, 0, 1, t.rdata);
        end
        chk({t.name, "_we"}, {31'd0, reg_write}, {31'd0, t.exp_we});
        chk({t.name, "_mis"}, {31'd0, misalign_err}, {31'd0, t.exp_mis});
        if (!t.exp_mis) chk({t.name, "_data"}, rd_data, t.exp_data);
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; mem_rsp_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    logic [CNT_W-1:0] cnt_snap;

    initial begin
        in_reg_write = 0; in_rd_addr = 0; in_wb_sel = 0; in_alu_result = 0;
        in_pc = 0; in_funct3 = 0; mem_rsp_data = 0;
        do_reset();
        #1;
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_count", {28'd0, retire_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 14; i++) run_vec(vt[i]);
        idle(1);

        // Back-to-back JAL then ALU to x0: one write then none, ready held high
        do_reset();
        step(1, 1, 1, 2'b10, 0, 32'h100, 0, 0, 0);
        chk("b2b_w1", {31'd0, reg_write}, 32'd1);
        chk("b2b_d1", rd_data, 32'h104);
        step(1, 1, 0, 2'b00, 32'h77, 0, 0, 0, 0);
        chk("b2b_w2", {31'd0, reg_write}, 32'd0);
        chk("b2b_cnt", {28'd0, retire_count}, 32'd2);

        // Stray response in IDLE is ignored
        cnt_snap = retire_count;
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("stray_we", {31'd0, reg_write}, 32'd0);
        chk("stray_cnt", {28'd0, retire_count}, {28'd0, cnt_snap});

        // Async reset in LOAD_WAIT, then a late response
        step(1, 1, 7, 2'b01, 32'h3, 0, 0, 0, 0);
        idle(1);
        chk("pre_rst_pend", {31'd0, load_pending}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_pend", {31'd0, load_pending}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_cnt", {28'd0, retire_count}, 32'd0);
        chk("mid_rst_load_rd", {27'd0, load_rd}, 32'd0);
        model_reset();
        @(posedge clk); #1 rst_n = 1;
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0000);
        chk("late_rsp_we", {31'd0, reg_write}, 32'd0);

        // Retire counter wrap with a 4-bit counter
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 1, 5'(i), 2'b00, 32'(i), 0, 0, 0, 0);
        chk("cnt_wrap", {28'd0, retire_count}, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, $urandom % 2,
                 (($urandom % 5) == 0) ? 5'd0 : 5'($urandom),
                 2'($urandom), $urandom, $urandom, 3'($urandom),
                 ($urandom % 3) == 0, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
